// File: rtl/x3q16_mem_arbiter.sv
// ============================================================================
// x3q16_mem_arbiter
// Shares the single x3q16 memory port between two requesters:
//   port 0 = CPU core, port 1 = DMA / UART-buffer master.
// Each requester issues a one-cycle request pulse. The pulse is captured into a
// per-port pending latch. One transaction at a time is forwarded to memory
// using the pulse-request / ready / write_complete handshake. The response is
// routed back to the owning port. A WAIT that runs too long is aborted, and
// the owning port receives a response pulse (read data all ones).
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   req_pulse[1:0]      per-port request strobe
//   req_type[1:0]       per-port 0 = read, 1 = write
//   req_addr/req_wdata  per-port address / write data, port 0 in the low slice
//   rsp_rdata           read data, valid while a rsp_ready bit is high
//   rsp_ready[1:0]      per-port read-done pulse
//   rsp_wdone[1:0]      per-port write-done pulse
//   drop_pulse[1:0]     per-port pulse: request discarded (port already busy)
//   timeout_pulse       pulse when a memory access is aborted
//   busy                high while a memory access is outstanding
//   mem_*               memory-side handshake
// ============================================================================
module x3q16_mem_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int FAIR    = 1,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      req_pulse,
    input  logic [1:0]      req_type,
    input  logic [2*AW-1:0] req_addr,
    input  logic [2*DW-1:0] req_wdata,
    output logic [DW-1:0]   rsp_rdata,
    output logic [1:0]      rsp_ready,
    output logic [1:0]      rsp_wdone,
    output logic [1:0]      drop_pulse,
    output logic            timeout_pulse,
    output logic            busy,
    output logic            mem_request,
    output logic            mem_type,
    output logic [AW-1:0]   mem_address,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ready,
    input  logic            mem_write_complete
);

    localparam int CW = $clog2(TIMEOUT + 1);
    // Abort on the edge that ends the TIMEOUT-th WAIT cycle (counter starts at 0).
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]             state_r;
    logic [1:0]             pending_r;
    logic [1:0]             type_r;
    logic [1:0][AW-1:0]     addr_r;
    logic [1:0][DW-1:0]     wdata_r;
    logic                   grant_r;
    logic                   last_grant_r;
    logic [CW-1:0]          cnt_r;

    logic                   done_s;
    logic                   tmo_s;
    logic [1:0]             clr_s;
    logic [1:0]             accept_s;
    logic [1:0]             drop_s;
    logic                   pick_s;

    // Winner selection. With both ports pending, round-robin prefers the port
    // that was not served last; otherwise the lowest pending port wins.
    function automatic logic pick_port(input logic [1:0] pend, input logic last);
        logic p;
        if ((FAIR != 0) && (pend == 2'b11)) begin
            p = ~last;
        end else if (pend[0]) begin
            p = 1'b0;
        end else begin
            p = 1'b1;
        end
        return p;
    endfunction

    // Completion / abort detection, capture acceptance and arbitration.
    always_comb begin
        done_s = 1'b0;
        tmo_s  = 1'b0;
        if (state_r == ST_WAIT) begin
            // Only the strobe matching the transaction type counts.
            if (mem_type ? mem_write_complete : mem_ready) begin
                done_s = 1'b1;
            end else if (cnt_r == TMO_LAST) begin
                tmo_s = 1'b1;
            end else begin
                tmo_s = 1'b0;
            end
        end else begin
            done_s = 1'b0;
        end
        clr_s    = (done_s | tmo_s) ? (grant_r ? 2'b10 : 2'b01) : 2'b00;
        // A port finishing on this edge may accept a new pulse (set beats clear).
        accept_s = req_pulse & (~pending_r | clr_s);
        drop_s   = req_pulse & pending_r & ~clr_s;
        pick_s   = pick_port(pending_r, last_grant_r);
    end

    // Per-port request capture and drop reporting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r  <= 2'b00;
            type_r     <= 2'b00;
            addr_r     <= '0;
            wdata_r    <= '0;
            drop_pulse <= 2'b00;
        end else begin
            pending_r  <= (pending_r & ~clr_s) | accept_s;
            drop_pulse <= drop_s;
            for (int p = 0; p < 2; p++) begin
                if (accept_s[p]) begin
                    type_r[p]  <= req_type[p];
                    addr_r[p]  <= req_addr[p*AW +: AW];
                    wdata_r[p] <= req_wdata[p*DW +: DW];
                end
            end
        end
    end

    // Transaction FSM: issue the winner, wait for completion or abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            grant_r       <= 1'b0;
            last_grant_r  <= 1'b1;
            cnt_r         <= '0;
            busy          <= 1'b0;
            mem_request   <= 1'b0;
            mem_type      <= 1'b0;
            mem_address   <= '0;
            mem_wdata     <= '0;
            rsp_rdata     <= '0;
            rsp_ready     <= 2'b00;
            rsp_wdone     <= 2'b00;
            timeout_pulse <= 1'b0;
        end else begin
            mem_request   <= 1'b0;
            rsp_ready     <= 2'b00;
            rsp_wdone     <= 2'b00;
            timeout_pulse <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pending_r != 2'b00) begin
                        mem_request <= 1'b1;
                        mem_type    <= type_r[pick_s];
                        mem_address <= addr_r[pick_s];
                        mem_wdata   <= wdata_r[pick_s];
                        grant_r     <= pick_s;
                        cnt_r       <= '0;
                        busy        <= 1'b1;
                        state_r     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (done_s || tmo_s) begin
                        if (mem_type) begin
                            rsp_wdone[grant_r] <= 1'b1;
                        end else begin
                            rsp_ready[grant_r] <= 1'b1;
                            rsp_rdata          <= done_s ? mem_rdata : {DW{1'b1}};
                        end
                        timeout_pulse <= tmo_s;
                        last_grant_r  <= grant_r;
                        busy          <= 1'b0;
                        state_r       <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_x3q16_mem_arbiter.sv
// Scoreboard bench: two arbiter instances (round-robin and fixed priority,
// both with TIMEOUT=8) share the requester stimulus; each has its own memory
// responder. Expected issues, responses and drops are queued by the stimulus
// and popped by a monitor when the DUT shows the corresponding output.
module tb_x3q16_mem_arbiter;

    typedef struct {
        int          cyc;
        logic        typ;
        logic [15:0] addr;
        logic [15:0] wdata;
    } iss_t;

    typedef struct {
        int          cyc;
        logic        wr;
        logic        port;
        logic [15:0] data;
        logic        to;
    } rsp_t;

    typedef struct {
        int   cyc;
        logic port;
    } drp_t;

    logic        clk;
    logic        reset;
    logic [1:0]  req_pulse;
    logic [1:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic [15:0] rsp_rdata_s   [2];
    logic [1:0]  rsp_ready_s   [2];
    logic [1:0]  rsp_wdone_s   [2];
    logic [1:0]  drop_s        [2];
    logic        to_s          [2];
    logic        busy_s        [2];
    logic        mem_request_s [2];
    logic        mem_type_s    [2];
    logic [15:0] mem_address_s [2];
    logic [15:0] mem_wdata_s   [2];
    logic        mem_ready_s   [2];
    logic        mem_wc_s      [2];
    logic [15:0] rd_val;

    int mem_lat;        // 0 = memory never answers
    int left [2];
    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    iss_t iss_q [2][$];
    rsp_t rsp_q [2][$];
    drp_t drp_q [2][$];

    x3q16_mem_arbiter #(.AW(16), .DW(16), .FAIR(1), .TIMEOUT(8)) u_fair (
        .clk(clk), .reset(reset), .req_pulse(req_pulse), .req_type(req_type),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_rdata(rsp_rdata_s[0]), .rsp_ready(rsp_ready_s[0]), .rsp_wdone(rsp_wdone_s[0]),
        .drop_pulse(drop_s[0]), .timeout_pulse(to_s[0]), .busy(busy_s[0]),
        .mem_request(mem_request_s[0]), .mem_type(mem_type_s[0]),
        .mem_address(mem_address_s[0]), .mem_wdata(mem_wdata_s[0]),
        .mem_rdata(rd_val), .mem_ready(mem_ready_s[0]), .mem_write_complete(mem_wc_s[0])
    );

    x3q16_mem_arbiter #(.AW(16), .DW(16), .FAIR(0), .TIMEOUT(8)) u_fixed (
        .clk(clk), .reset(reset), .req_pulse(req_pulse), .req_type(req_type),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_rdata(rsp_rdata_s[1]), .rsp_ready(rsp_ready_s[1]), .rsp_wdone(rsp_wdone_s[1]),
        .drop_pulse(drop_s[1]), .timeout_pulse(to_s[1]), .busy(busy_s[1]),
        .mem_request(mem_request_s[1]), .mem_type(mem_type_s[1]),
        .mem_address(mem_address_s[1]), .mem_wdata(mem_wdata_s[1]),
        .mem_rdata(rd_val), .mem_ready(mem_ready_s[1]), .mem_write_complete(mem_wc_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: the strobe is high mem_lat cycles after mem_request.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) left[i] <= 0;
            else if (mem_request_s[i]) left[i] <= mem_lat;
            else if (left[i] != 0) left[i] <= left[i] - 1;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            mem_ready_s[i] = (left[i] == 1) && !mem_type_s[i];
            mem_wc_s[i]    = (left[i] == 1) &&  mem_type_s[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare whenever either DUT presents an output event.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_request_s[i]) begin
                if (iss_q[i].size() == 0) begin
                    chk($sformatf("u%0d_unexpected_issue", i), 32'd1, 32'd0);
                end else begin
                    iss_t e;
                    e = iss_q[i].pop_front();
                    chk($sformatf("u%0d_mem_type", i), {31'd0, mem_type_s[i]}, {31'd0, e.typ});
                    chk($sformatf("u%0d_mem_address", i), {16'd0, mem_address_s[i]}, {16'd0, e.addr});
                    if (e.typ) chk($sformatf("u%0d_mem_wdata", i), {16'd0, mem_wdata_s[i]}, {16'd0, e.wdata});
                    if (e.cyc >= 0) chk($sformatf("u%0d_issue_cycle", i), cyc, e.cyc);
                end
            end
            if ((rsp_ready_s[i] != 2'b00) || (rsp_wdone_s[i] != 2'b00) || to_s[i]) begin
                if (rsp_q[i].size() == 0) begin
                    chk($sformatf("u%0d_unexpected_rsp", i), 32'd1, 32'd0);
                end else begin
                    rsp_t r;
                    logic [1:0] pm;
                    r  = rsp_q[i].pop_front();
                    pm = r.port ? 2'b10 : 2'b01;
                    chk($sformatf("u%0d_rsp_ready", i), {30'd0, rsp_ready_s[i]}, r.wr ? 32'd0 : {30'd0, pm});
                    chk($sformatf("u%0d_rsp_wdone", i), {30'd0, rsp_wdone_s[i]}, r.wr ? {30'd0, pm} : 32'd0);
                    chk($sformatf("u%0d_timeout_pulse", i), {31'd0, to_s[i]}, {31'd0, r.to});
                    if (!r.wr) chk($sformatf("u%0d_rsp_rdata", i), {16'd0, rsp_rdata_s[i]}, {16'd0, r.data});
                    if (r.cyc >= 0) chk($sformatf("u%0d_rsp_cycle", i), cyc, r.cyc);
                end
            end
            if (drop_s[i] != 2'b00) begin
                if (drp_q[i].size() == 0) begin
                    chk($sformatf("u%0d_unexpected_drop", i), 32'd1, 32'd0);
                end else begin
                    drp_t d;
                    d = drp_q[i].pop_front();
                    chk($sformatf("u%0d_drop_pulse", i), {30'd0, drop_s[i]}, d.port ? 32'd2 : 32'd1);
                    chk($sformatf("u%0d_drop_cycle", i), cyc, d.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic pulse(input logic [1:0] p);
        req_pulse = p;
        tick();
        req_pulse = 2'b00;
    endtask

    task automatic push_iss(input int i, input int c, input logic t, input logic [15:0] a, input logic [15:0] d);
        iss_t e;
        e.cyc = c; e.typ = t; e.addr = a; e.wdata = d;
        iss_q[i].push_back(e);
    endtask

    task automatic push_rsp(input int i, input int c, input logic wr, input logic p, input logic [15:0] d, input logic to);
        rsp_t r;
        r.cyc = c; r.wr = wr; r.port = p; r.data = d; r.to = to;
        rsp_q[i].push_back(r);
    endtask

    task automatic push_drop(input int i, input int c, input logic p);
        drp_t d;
        d.cyc = c; d.port = p;
        drp_q[i].push_back(d);
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 200;
        while (budget > 0 && (iss_q[0].size() + iss_q[1].size() + rsp_q[0].size() + rsp_q[1].size()
                              + drp_q[0].size() + drp_q[1].size()) != 0) begin
            tick();
            budget--;
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_u%0d_missing_issue", name, i), iss_q[i].size(), 32'd0);
            chk($sformatf("%s_u%0d_missing_rsp", name, i), rsp_q[i].size(), 32'd0);
            chk($sformatf("%s_u%0d_missing_drop", name, i), drp_q[i].size(), 32'd0);
        end
        repeat (4) tick();
    endtask

    task automatic do_reset(input string name);
        reset     = 1'b1;
        req_pulse = 2'b00;
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_u%0d_busy", name, i), {31'd0, busy_s[i]}, 32'd0);
            chk($sformatf("%s_u%0d_mem_request", name, i), {31'd0, mem_request_s[i]}, 32'd0);
            chk($sformatf("%s_u%0d_rsp", name, i),
                {26'd0, rsp_ready_s[i], rsp_wdone_s[i], drop_s[i]}, 32'd0);
            chk($sformatf("%s_u%0d_addr_rdata", name, i), {mem_address_s[i], rsp_rdata_s[i]}, 32'd0);
            iss_q[i].delete();
            rsp_q[i].delete();
            drp_q[i].delete();
        end
        reset = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int pt;
        logic [1:0] fixed_ports [4];
        reset     = 1'b1;
        req_pulse = 2'b00;
        req_type  = 2'b00;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        rd_val    = 16'h0000;
        mem_lat   = 3;
        do_reset("reset");

        // 1: single CPU read, memory answers 3 cycles after the request.
        mem_lat = 3; rd_val = 16'hBEEF; req_type = 2'b00;
        req_addr = {16'h0000, 16'h0010};
        n = cyc;
        for (int i = 0; i < 2; i++) begin
            push_iss(i, n + 2, 1'b0, 16'h0010, 16'h0000);
            push_rsp(i, n + 6, 1'b0, 1'b0, 16'hBEEF, 1'b0);
        end
        pulse(2'b01);
        drain("t1");

        // 2: simultaneous CPU read and DMA write, CPU served first.
        do_reset("t2rst");
        mem_lat = 2; rd_val = 16'h5555; req_type = 2'b10;
        req_addr = {16'h0200, 16'h0001}; req_wdata = {16'h1234, 16'h0000};
        n = cyc;
        for (int i = 0; i < 2; i++) begin
            push_iss(i, n + 2, 1'b0, 16'h0001, 16'h0000);
            push_rsp(i, n + 5, 1'b0, 1'b0, 16'h5555, 1'b0);
            push_iss(i, n + 6, 1'b1, 16'h0200, 16'h1234);
            push_rsp(i, n + 9, 1'b1, 1'b1, 16'h0000, 1'b0);
        end
        pulse(2'b11);
        drain("t2");

        // 3: sustained contention; each port re-pulses on its own completion edge.
        do_reset("t3rst");
        mem_lat = 4; rd_val = 16'h0F0F; req_type = 2'b10;
        req_addr = {16'h00B1, 16'h00A0}; req_wdata = {16'h7777, 16'h0000};
        n = cyc;
        for (int k = 0; k < 5; k++) begin
            pt = k % 2;
            push_iss(0, n + 2 + 6*k, pt[0], pt[0] ? 16'h00B1 : 16'h00A0, 16'h7777);
            push_rsp(0, n + 7 + 6*k, pt[0], pt[0], 16'h0F0F, 1'b0);
        end
        fixed_ports[0] = 2'd0; fixed_ports[1] = 2'd0; fixed_ports[2] = 2'd1; fixed_ports[3] = 2'd0;
        for (int k = 0; k < 4; k++) begin
            push_iss(1, n + 2 + 6*k, fixed_ports[k][0], fixed_ports[k][0] ? 16'h00B1 : 16'h00A0, 16'h7777);
            push_rsp(1, n + 7 + 6*k, fixed_ports[k][0], fixed_ports[k][0], 16'h0F0F, 1'b0);
        end
        push_drop(1, n + 13, 1'b1);
        pulse(2'b11);
        wait_cyc(n + 6);  pulse(2'b01);
        wait_cyc(n + 12); pulse(2'b10);
        wait_cyc(n + 18); pulse(2'b01);
        drain("t3");

        // 4: CPU re-pulses while its read is outstanding.
        do_reset("t4rst");
        mem_lat = 4; rd_val = 16'h4444; req_type = 2'b00;
        req_addr = {16'h0000, 16'h0044};
        n = cyc;
        for (int i = 0; i < 2; i++) begin
            push_iss(i, n + 2, 1'b0, 16'h0044, 16'h0000);
            push_drop(i, n + 4, 1'b0);
            push_rsp(i, n + 7, 1'b0, 1'b0, 16'h4444, 1'b0);
        end
        pulse(2'b01);
        wait_cyc(n + 3); pulse(2'b01);
        drain("t4");

        // 5: silent memory aborts the CPU read; queued DMA write then completes.
        do_reset("t5rst");
        mem_lat = 0; rd_val = 16'h1111; req_type = 2'b10;
        req_addr = {16'h0066, 16'h0055}; req_wdata = {16'hABCD, 16'h0000};
        n = cyc;
        for (int i = 0; i < 2; i++) begin
            push_iss(i, n + 2, 1'b0, 16'h0055, 16'h0000);
            push_rsp(i, n + 10, 1'b0, 1'b0, 16'hFFFF, 1'b1);
            push_iss(i, n + 11, 1'b1, 16'h0066, 16'hABCD);
            push_rsp(i, n + 14, 1'b1, 1'b1, 16'h0000, 1'b0);
        end
        pulse(2'b01);
        pulse(2'b10);
        wait_cyc(n + 5); mem_lat = 2;
        drain("t5");

        // 6: reset during WAIT abandons the read; a later DMA read runs normally.
        do_reset("t6rst");
        mem_lat = 5; rd_val = 16'h9999; req_type = 2'b00;
        req_addr = {16'h0099, 16'h0077};
        n = cyc;
        for (int i = 0; i < 2; i++) push_iss(i, n + 2, 1'b0, 16'h0077, 16'h0000);
        pulse(2'b01);
        wait_cyc(n + 4);
        do_reset("t6mid");
        repeat (8) tick();
        mem_lat = 2;
        n = cyc;
        for (int i = 0; i < 2; i++) begin
            push_iss(i, n + 2, 1'b0, 16'h0099, 16'h0000);
            push_rsp(i, n + 5, 1'b0, 1'b1, 16'h9999, 1'b0);
        end
        pulse(2'b10);
        drain("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
